// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack1 serial program loader.
package hack_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [1:0] {
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx
    import hack_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      byte_valid,
    output logic                      frame_err
);

    localparam int unsigned HALF     = CLKS_PER_BIT / 2;
    localparam int unsigned STOP_END = UART_STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CW       = $clog2(STOP_END + 1);
    localparam int unsigned BW       = $clog2(UART_DATA_BITS);

    rx_state_e                 r_state;
    logic                      r_rx_meta;
    logic                      r_rx_s;
    logic                      r_rx_prev;
    logic [CW-1:0]             r_cnt;
    logic [BW-1:0]             r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_byte_valid;
    logic                      r_frame_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RX_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            r_rx_prev    <= r_rx_s;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at its midpoint was a glitch.
                    if (r_cnt == CW'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit == BW'(UART_DATA_BITS - 1)) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CW'(STOP_END - 1)) begin
                        r_byte_valid <= r_rx_s;
                        r_frame_err  <= ~r_rx_s;
                        r_state      <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign data       = r_shift;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/rom_loader.sv
// Serial Hack program loader: count-prefixed word stream from UART into instruction memory,
// holding the CPU in reset while the load runs.
module rom_loader
    import hack_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DEPTH        = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic        loadRUN,
    output logic        romLoad,
    output logic [15:0] romAddress,
    output logic [15:0] romIn,
    output logic        loadErr
);

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    logic [7:0]    w_byte;
    logic          w_byte_valid;
    logic          w_frame_err;

    loader_state_e r_state;
    logic [7:0]    r_cnt_hi;
    logic [7:0]    r_hi;
    logic [15:0]   r_remain;
    logic [15:0]   r_addr;
    logic          r_load_run;
    logic          r_rom_load;
    logic [15:0]   r_rom_addr;
    logic [15:0]   r_rom_in;
    logic          r_load_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .data      (w_byte),
        .byte_valid(w_byte_valid),
        .frame_err (w_frame_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CNT_HI;
            r_cnt_hi   <= '0;
            r_hi       <= '0;
            r_remain   <= '0;
            r_addr     <= '0;
            r_load_run <= 1'b0;
            r_rom_load <= 1'b0;
            r_rom_addr <= '0;
            r_rom_in   <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_rom_load <= 1'b0;
            if (w_frame_err) begin
                r_load_err <= 1'b1;
            end
            if (w_byte_valid) begin
                case (r_state)
                    CNT_HI: begin
                        r_cnt_hi   <= w_byte;
                        r_load_run <= 1'b1;
                        r_load_err <= 1'b0;
                        r_state    <= CNT_LO;
                    end
                    CNT_LO: begin
                        r_remain <= {r_cnt_hi, w_byte};
                        r_addr   <= '0;
                        if ({r_cnt_hi, w_byte} == 16'd0) begin
                            r_load_run <= 1'b0;
                            r_state    <= CNT_HI;
                        end else begin
                            r_state <= DAT_HI;
                        end
                    end
                    DAT_HI: begin
                        r_hi    <= w_byte;
                        r_state <= DAT_LO;
                    end
                    DAT_LO: begin
                        r_rom_in   <= {r_hi, w_byte};
                        r_rom_addr <= r_addr;
                        // Words past the end of memory are dropped but still consumed.
                        if ({1'b0, r_addr} < DEPTH_LIM) begin
                            r_rom_load <= 1'b1;
                        end else begin
                            r_load_err <= 1'b1;
                        end
                        r_addr   <= r_addr + 16'd1;
                        r_remain <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_load_run <= 1'b0;
                            r_state    <= CNT_HI;
                        end else begin
                            r_state <= DAT_HI;
                        end
                    end
                    default: r_state <= CNT_HI;
                endcase
            end
        end
    end

    assign loadRUN    = r_load_run;
    assign romLoad    = r_rom_load;
    assign romAddress = r_rom_addr;
    assign romIn      = r_rom_in;
    assign loadErr    = r_load_err;

endmodule
